// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared encodings for the multiply/divide sequencer.
// Holds the MD op codes, FSM state codes and default latency constants.
package md_sequencer_pkg;

    // MD operation encodings as presented on the op bus from E.
    typedef enum logic [2:0] {
        MD_mfhi  = 3'd0,
        MD_mflo  = 3'd1,
        MD_mthi  = 3'd2,
        MD_mtlo  = 3'd3,
        MD_mult  = 3'd4,
        MD_multu = 3'd5,
        MD_div   = 3'd6,
        MD_divu  = 3'd7
    } md_op_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_MUL  = 2'd1,
        MDS_DIV  = 2'd2
    } md_state_e;

    // Default busy latencies; both must stay within 1..15.
    localparam int DEF_MULT_CYC = 5;
    localparam int DEF_DIV_CYC  = 10;

    // Width of the latency down-counter (enough for 15).
    localparam int CNT_W = 4;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_mult) || (op == MD_multu);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_div) || (op == MD_divu);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: E-stage to MD sequencer bus.
// master = pipeline side issuing operations, slave = the sequencer.
interface md_sequencer_if;
    logic        en;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output en, op, rs_data, rt_data,
        input  busy, stall_md, hi, lo, rd_data
    );

    modport slave (
        input  en, op, rs_data, rt_data,
        output busy, stall_md, hi, lo, rd_data
    );
endinterface

// File: rtl/md_sequencer_arith.sv
// md_arith: combinational MD datapath. Produces the {hi, lo} result that the
// sequencer parks in its pending registers at issue time, including the
// divide-by-zero and -2^31/-1 overflow results.
import md_sequencer_pkg::*;

module md_arith (
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result
);

    logic        is_signed;
    logic [63:0] rs_ext;
    logic [63:0] rt_ext;
    logic [63:0] product;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Odd op codes (multu, divu) are the unsigned variants.
    assign is_signed = ~op[0];

    // Multiply: sign- or zero-extend to 64 bits, keep the low 64 bits.
    // Divide: work on magnitudes, then restore signs so the quotient
    // truncates toward zero and the remainder follows the dividend.
    always_comb begin
        rs_ext  = is_signed ? {{32{rs[31]}}, rs} : {32'd0, rs};
        rt_ext  = is_signed ? {{32{rt[31]}}, rt} : {32'd0, rt};
        product = rs_ext * rt_ext;

        rs_neg  = is_signed & rs[31];
        rt_neg  = is_signed & rt[31];
        rs_mag  = rs_neg ? (32'd0 - rs) : rs;
        rt_mag  = rt_neg ? (32'd0 - rt) : rt;
        q_mag   = (rt_mag == 32'd0) ? 32'd0 : (rs_mag / rt_mag);
        r_mag   = (rt_mag == 32'd0) ? 32'd0 : (rs_mag % rt_mag);
        quot    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = rs_neg ? (32'd0 - r_mag) : r_mag;

        result  = 64'd0;
        if (op[2]) begin
            if (!op[1]) begin
                result = product;
            end else if (rt == 32'd0) begin
                // Divide by zero: all-ones quotient, dividend left in HI.
                result = {rs, 32'hFFFF_FFFF};
            end else if (is_signed && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
                // The one signed quotient that does not fit: pin it.
                result = {32'd0, 32'h8000_0000};
            end else begin
                result = {rem, quot};
            end
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer for the P6 pipeline. Owns HI/LO,
// models MULT_CYC / DIV_CYC latency and reports busy / stall_md to hazard
// control. Optional build macro MD_DIV0_GUARD_EN: when defined, a div/divu
// with rt_data==0 is dropped at issue instead of running full latency.
import md_sequencer_pkg::*;

module md_sequencer #(
    parameter int MULT_CYC = DEF_MULT_CYC,
    parameter int DIV_CYC  = DEF_DIV_CYC
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);

    md_state_e         state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              busy_reg;
    logic [31:0]       hi_reg;
    logic [31:0]       lo_reg;
    logic [31:0]       pend_hi_reg;
    logic [31:0]       pend_lo_reg;
    logic [63:0]       arith_res;
    logic              mul_start;
    logic              div_start;

    md_arith u_arith (
        .op     (md.op),
        .rs     (md.rs_data),
        .rt     (md.rt_data),
        .result (arith_res)
    );

    assign mul_start = md.en & is_mul(md.op);

`ifdef MD_DIV0_GUARD_EN
    // A zero divisor never starts; the op is silently dropped.
    assign div_start = md.en & is_div(md.op) & (md.rt_data != 32'd0);
`else
    assign div_start = md.en & is_div(md.op);
`endif

    // Sequencer FSM: issue from IDLE, count down latency, then commit HI/LO.
    // Anything presented on en while busy is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= MDS_IDLE;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
        end else begin
            case (state_reg)
                MDS_IDLE: begin
                    if (mul_start) begin
                        pend_hi_reg <= arith_res[63:32];
                        pend_lo_reg <= arith_res[31:0];
                        count_reg   <= CNT_W'(MULT_CYC - 1);
                        busy_reg    <= 1'b1;
                        state_reg   <= MDS_MUL;
                    end else if (div_start) begin
                        pend_hi_reg <= arith_res[63:32];
                        pend_lo_reg <= arith_res[31:0];
                        count_reg   <= CNT_W'(DIV_CYC - 1);
                        busy_reg    <= 1'b1;
                        state_reg   <= MDS_DIV;
                    end else if (md.en && md.op == MD_mthi) begin
                        hi_reg <= md.rs_data;
                    end else if (md.en && md.op == MD_mtlo) begin
                        lo_reg <= md.rs_data;
                    end
                end
                MDS_MUL, MDS_DIV: begin
                    if (count_reg != '0) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end else begin
                        hi_reg    <= pend_hi_reg;
                        lo_reg    <= pend_lo_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= MDS_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= MDS_IDLE;
                end
            endcase
        end
    end

    // stall_md covers the issue cycle too, so the instruction directly
    // behind an MD op in D is held even before busy rises.
    assign md.busy     = busy_reg;
    assign md.stall_md = busy_reg | (md.en & md.op[2]);
    assign md.hi       = hi_reg;
    assign md.lo       = lo_reg;
    assign md.rd_data  = (md.op == MD_mflo) ? lo_reg : hi_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven check of md_sequencer with default latencies
// (mult 5, div 10), plus hand sequences for busy-time issue, mid-op reset
// and divide by zero (behaviour follows MD_DIV0_GUARD_EN when defined).
import md_sequencer_pkg::*;

module tb_md_sequencer;

    localparam int BUSY_LIMIT = 40;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk;
    logic reset;
    int   total_cnt;
    int   pass_cnt;
    vec_t vecs[10];

    md_sequencer_if md_if ();

    md_sequencer #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Present one op for one cycle (from a negedge), checking stall_md in the
    // issue cycle; returns at the negedge after the issue edge.
    task automatic issue(input string name, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_if.en = 1'b1; md_if.op = o; md_if.rs_data = a; md_if.rt_data = b;
        #1 chk({name, " stall_md@issue"}, 32'(md_if.stall_md), 32'(o[2]));
        @(negedge clk);
        md_if.en = 1'b0; md_if.op = MD_mfhi;
    endtask

    // Count cycles busy is seen high, bounded.
    task automatic count_busy(input int start, output int cycles);
        cycles = start;
        while (md_if.busy && cycles < BUSY_LIMIT) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input logic [31:0] eh, input logic [31:0] el);
        chk({name, " hi"}, md_if.hi, eh);
        chk({name, " lo"}, md_if.lo, el);
        md_if.op = MD_mfhi;
        #1 chk({name, " mfhi"}, md_if.rd_data, eh);
        md_if.op = MD_mflo;
        #1 chk({name, " mflo"}, md_if.rd_data, el);
        md_if.op = MD_mfhi;
    endtask

    initial begin
        int cyc;
        total_cnt = 0;
        pass_cnt  = 0;

        vecs[0] = '{"mult -2*3",     MD_mult,  32'hFFFF_FFFE, 32'h0000_0003, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"multu",         MD_multu, 32'hFFFF_FFFE, 32'h0000_0003, 5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{"div -7/2",      MD_div,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu 7/2",      MD_divu,  32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{"div ovf",       MD_div,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{"mthi",          MD_mthi,  32'h1234_5678, 32'h0000_0000, 0,  32'h1234_5678, 32'h8000_0000};
        vecs[6] = '{"mtlo",          MD_mtlo,  32'hCAFE_BABE, 32'h0000_0000, 0,  32'h1234_5678, 32'hCAFE_BABE};
        vecs[7] = '{"div 7/-2",      MD_div,   32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{"mult min*min",  MD_mult,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};
        vecs[9] = '{"multu max*max", MD_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};

        md_if.en = 1'b0; md_if.op = MD_mfhi; md_if.rs_data = '0; md_if.rt_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 32'(md_if.busy), 32'd0);
        chk("reset stall_md", 32'(md_if.stall_md), 32'd0);
        chk("reset hi", md_if.hi, 32'd0);
        chk("reset lo", md_if.lo, 32'd0);

        // Table-driven main function.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt);
            count_busy(0, cyc);
            chk({vecs[i].name, " busy cycles"}, 32'(cyc), 32'(vecs[i].cycles));
            check_result(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
            $display("op %s rs=%h rt=%h busy=%0d hi=%h lo=%h", vecs[i].name,
                     vecs[i].rs, vecs[i].rt, cyc, md_if.hi, md_if.lo);
        end

        // mtlo presented while a mult is in flight must be ignored.
        issue("mult 2*3", MD_mult, 32'd2, 32'd3);
        md_if.en = 1'b1; md_if.op = MD_mtlo; md_if.rs_data = 32'hDEAD_BEEF;
        #1 chk("mtlo busy stall_md", 32'(md_if.stall_md), 32'd1);
        @(negedge clk);
        md_if.en = 1'b0; md_if.op = MD_mfhi;
        count_busy(1, cyc);
        chk("mtlo busy cycles", 32'(cyc), 32'd5);
        check_result("mtlo busy", 32'd0, 32'd6);
        $display("mtlo-while-busy busy=%0d hi=%h lo=%h", cyc, md_if.hi, md_if.lo);

        // Reset in the third busy cycle of a div.
        issue("div rst", MD_divu, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        chk("rst busy before", 32'(md_if.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst busy", 32'(md_if.busy), 32'd0);
        chk("rst hi", md_if.hi, 32'd0);
        chk("rst lo", md_if.lo, 32'd0);
        issue("mult after rst", MD_mult, 32'd7, 32'd6);
        count_busy(0, cyc);
        chk("mult after rst cycles", 32'(cyc), 32'd5);
        check_result("mult after rst", 32'd0, 32'd42);
        $display("reset-mid-div then mult busy=%0d hi=%h lo=%h", cyc, md_if.hi, md_if.lo);

        // Divide by zero.
        issue("div0", MD_div, 32'd5, 32'd0);
        count_busy(0, cyc);
`ifdef MD_DIV0_GUARD_EN
        chk("div0 busy cycles", 32'(cyc), 32'd0);
        check_result("div0", 32'd0, 32'd42);
`else
        chk("div0 busy cycles", 32'(cyc), 32'd10);
        check_result("div0", 32'd5, 32'hFFFF_FFFF);
`endif
        $display("div0 busy=%0d hi=%h lo=%h", cyc, md_if.hi, md_if.lo);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
